mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It generates every datapath enable and select, including the `NPCOp` command and `PCWr` strobe consumed by the next-PC logic and PC register. It is the initiator side of the next-PC interface: it decides when the PC advances and which NPC mode (sequential, branch, jump) is applied.

---
 rtl/mc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control unit for the MIPS datapath.
//
// Each instruction is stepped through FETCH, DCD and then a class-specific
// path (memory, ALU, branch, jump). Every datapath enable and select is
// produced here, including the next-PC mode (NPCOp) and the PC load strobe
// (PCWr), so this block decides when the PC advances and how.
//
// Ports:
//   clk, rst_n       clock (rising edge) / asynchronous active-low reset
//   Op, Funct        IR[31:26] / IR[5:0], valid from DCD onward
//   Zero             ALU equality flag, only looked at in BR
//   PCWr, NPCOp      PC load enable / next-PC mode (00 +4, 01 branch, 10 jump)
//   IRWr, RFWr, DMWr IR load / register file write / data memory write
//   ALUOp            00 add, 01 sub, 10 or
//   EXTOp            00 zero-ext, 01 sign-ext, 10 imm<<16
//   BSel             ALU B: 0 rt, 1 extended immediate
//   GPRSel           write register: 0 rd, 1 rt
//   WDSel            write data: 0 ALU result, 1 memory data
//   Illegal          one-cycle pulse in DCD for an unsupported instruction
//   State            current state code (debug)
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic       BSel,
  output logic       GPRSel,
  output logic       WDSel,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DCD = 4'd1, S_MA  = 4'd2, S_MR  = 4'd3, S_MWB = 4'd4,
    S_MW    = 4'd5, S_EXE = 4'd6, S_AWB = 4'd7, S_BR  = 4'd8, S_JMP = 4'd9
  } state_t;

  state_t state_q, state_d;

  // instruction decode from the IR fields
  logic is_r, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  assign is_r    = (Op == 6'b000000);
  assign is_addu = is_r && (Funct == 6'b100001);
  assign is_subu = is_r && (Funct == 6'b100011);
  assign is_ori  = (Op == 6'b001101);
  assign is_lui  = (Op == 6'b001111);
  assign is_lw   = (Op == 6'b100011);
  assign is_sw   = (Op == 6'b101011);
  assign is_beq  = (Op == 6'b000100);
  assign is_j    = (Op == 6'b000010);

  // raw enables before reset gating
  logic pcwr, irwr, rfwr, dmwr, ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    rfwr    = 1'b0;
    dmwr    = 1'b0;
    ill     = 1'b0;
    NPCOp   = NPC_PLUS4;
    ALUOp   = ALU_ADD;
    EXTOp   = EXT_ZERO;
    BSel    = 1'b0;
    GPRSel  = 1'b0;
    WDSel   = 1'b0;
    case (state_q)
      S_FETCH: begin
        pcwr    = 1'b1;
        irwr    = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        if (is_lw || is_sw)                    state_d = S_MA;
        else if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXE;
        else if (is_beq)                       state_d = S_BR;
        else if (is_j)                         state_d = S_JMP;
        else begin
          state_d = S_FETCH;
          ill     = 1'b1;
        end
      end
      S_MA: begin
        ALUOp   = ALU_ADD;
        BSel    = 1'b1;
        EXTOp   = EXT_SIGN;
        state_d = is_lw ? S_MR : S_MW;
      end
      S_MR:  state_d = S_MWB;
      S_MWB: begin
        rfwr   = 1'b1;
        GPRSel = 1'b1;
        WDSel  = 1'b1;
      end
      S_MW: dmwr = 1'b1;
      // AWB keeps the EXE operand selects so the ALU result stays stable
      S_EXE, S_AWB: begin
        if (is_r) begin
          ALUOp = is_subu ? ALU_SUB : ALU_ADD;
          BSel  = 1'b0;
        end else begin
          ALUOp = ALU_OR;
          BSel  = 1'b1;
          EXTOp = is_lui ? EXT_LUI : EXT_ZERO;
        end
        if (state_q == S_EXE) state_d = S_AWB;
        else begin
          rfwr   = 1'b1;
          GPRSel = !is_r;
        end
      end
      // PC already holds PC+4 here, so the NPC branch target is PC+4+offset
      S_BR: begin
        ALUOp = ALU_SUB;
        BSel  = 1'b0;
        EXTOp = EXT_SIGN;
        NPCOp = NPC_BRANCH;
        pcwr  = Zero;
      end
      S_JMP: begin
        NPCOp = NPC_JUMP;
        pcwr  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the enables combinationally so an asynchronous reset kills
  // any write strobe at once, not just at the next edge.
  assign PCWr    = pcwr & rst_n;
  assign IRWr    = irwr & rst_n;
  assign RFWr    = rfwr & rst_n;
  assign DMWr    = dmwr & rst_n;
  assign Illegal = ill  & rst_n;
  assign State   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle outputs; one compare process checks every
// cycle at the falling edge. Literal checks pin reset behaviour and the
// per-instruction strobe counts.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWr, IRWr, RFWr, DMWr, BSel, GPRSel, WDSel, Illegal;
  logic [1:0] NPCOp, ALUOp, EXTOp;
  logic [3:0] State;

  int nvec = 0;
  int nerr = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .BSel(BSel), .GPRSel(GPRSel),
    .WDSel(WDSel), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr;
    logic [1:0] npcop;
    logic       irwr, rfwr, dmwr;
    logic [1:0] aluop, extop;
    logic       bsel, gprsel, wdsel, ill;
  } vec_t;

  vec_t q[$];

  function automatic vec_t actual();
    vec_t a;
    a = '{State, PCWr, NPCOp, IRWr, RFWr, DMWr, ALUOp, EXTOp, BSel, GPRSel,
          WDSel, Illegal};
    return a;
  endfunction

  function automatic bit legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b100001) || (fn == 6'b100011);
    return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011,
                      6'b000100, 6'b000010};
  endfunction

  // State path each instruction class walks through
  function automatic void path(logic [5:0] op, logic [5:0] fn, output int p[$]);
    p = '{0, 1};
    if (!legal(op, fn))    return;
    if (op == 6'b100011)   p = '{0, 1, 2, 3, 4};
    else if (op == 6'b101011) p = '{0, 1, 2, 5};
    else if (op == 6'b000100) p = '{0, 1, 8};
    else if (op == 6'b000010) p = '{0, 1, 9};
    else                   p = '{0, 1, 6, 7};
  endfunction

  // What the datapath must see in a given state for a given instruction
  function automatic vec_t outs(int st, logic [5:0] op, logic [5:0] fn, logic z);
    vec_t e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.pcwr = 1; e.irwr = 1; end
      1: e.ill = !legal(op, fn);
      2: begin e.aluop = 2'b00; e.bsel = 1; e.extop = 2'b01; end
      4: begin e.rfwr = 1; e.gprsel = 1; e.wdsel = 1; end
      5: e.dmwr = 1;
      6, 7: begin
        if (op == 6'b000000) e.aluop = (fn == 6'b100011) ? 2'b01 : 2'b00;
        else begin
          e.aluop = 2'b10;
          e.bsel  = 1;
          e.extop = (op == 6'b001111) ? 2'b10 : 2'b00;
        end
        if (st == 7) begin e.rfwr = 1; e.gprsel = (op != 6'b000000); end
      end
      8: begin e.aluop = 2'b01; e.extop = 2'b01; e.npcop = 2'b01; e.pcwr = z; end
      9: begin e.npcop = 2'b10; e.pcwr = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Per-cycle compare against the model queue
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      vec_t e, a;
      e = q.pop_front();
      a = actual();
      nvec++;
      if (a !== e) begin
        nerr++;
        $display("FAIL cycle t=%0t st=%0d: got %h want %h", $time, e.st, a, e);
      end
    end
  end

  // Running strobe counters (only read as deltas by the driver)
  int pc_cnt = 0, rf_cnt = 0, dm_cnt = 0, ill_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      pc_cnt  <= pc_cnt + int'(PCWr);
      rf_cnt  <= rf_cnt + int'(RFWr);
      dm_cnt  <= dm_cnt + int'(DMWr);
      ill_cnt <= ill_cnt + int'(Illegal);
    end
  end

  task automatic check(string name, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the
  // next instruction's FETCH.
  task automatic apply(logic [5:0] op, logic [5:0] fn, logic z);
    int p[$];
    Op = op; Funct = fn; Zero = z;
    path(op, fn, p);
    foreach (p[i]) q.push_back(outs(p[i], op, fn, z));
    repeat (p.size()) @(posedge clk);
    #1;
  endtask

  // Runs one instruction and pins its strobe counts to literal values
  task automatic run_cnt(string name, logic [5:0] op, logic [5:0] fn, logic z,
                         int pc, int rf, int dm, int il);
    int pc0, rf0, dm0, il0;
    pc0 = pc_cnt; rf0 = rf_cnt; dm0 = dm_cnt; il0 = ill_cnt;
    apply(op, fn, z);
    check({name, " PCWr count"},    pc_cnt - pc0, pc);
    check({name, " RFWr count"},    rf_cnt - rf0, rf);
    check({name, " DMWr count"},    dm_cnt - dm0, dm);
    check({name, " Illegal count"}, ill_cnt - il0, il);
  endtask

  initial begin
    rst_n = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
    #3;
    check("reset outputs", int'(actual()), 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset state held", int'(State), 0);
    rst_n = 1'b1;

    // Zero=1 outside BR must be ignored
    run_cnt("lw",   6'b100011, 6'b000000, 1'b1, 1, 1, 0, 0);
    run_cnt("sw",   6'b101011, 6'b000000, 1'b0, 1, 0, 1, 0);
    run_cnt("beq1", 6'b000100, 6'b000000, 1'b1, 2, 0, 0, 0);
    run_cnt("beq0", 6'b000100, 6'b000000, 1'b0, 1, 0, 0, 0);
    run_cnt("j",    6'b000010, 6'b000000, 1'b0, 2, 0, 0, 0);
    run_cnt("addu", 6'b000000, 6'b100001, 1'b0, 1, 1, 0, 0);
    run_cnt("subu", 6'b000000, 6'b100011, 1'b1, 1, 1, 0, 0);
    run_cnt("ori",  6'b001101, 6'b100011, 1'b0, 1, 1, 0, 0);
    run_cnt("lui",  6'b001111, 6'b000000, 1'b0, 1, 1, 0, 0);
    run_cnt("ill op",  6'b111111, 6'b000000, 1'b0, 1, 0, 0, 1);
    run_cnt("ill fn0", 6'b000000, 6'b000000, 1'b0, 1, 0, 0, 1);
    run_cnt("ill add", 6'b000000, 6'b100000, 1'b0, 1, 0, 0, 1);

    // sw interrupted by an asynchronous reset while in MW
    Op = 6'b101011; Funct = '0; Zero = 1'b0;
    q.push_back(outs(0, Op, Funct, 1'b0));
    q.push_back(outs(1, Op, Funct, 1'b0));
    q.push_back(outs(2, Op, Funct, 1'b0));
    q.push_back(outs(5, Op, Funct, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort DMWr", int'(DMWr), 0);
    check("abort State", int'(State), 0);
    check("abort PCWr", int'(PCWr), 0);
    check("abort queue drained", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cnt("lw after abort", 6'b100011, 6'b000000, 1'b0, 1, 1, 0, 0);
    run_cnt("j after abort",  6'b000010, 6'b000000, 1'b1, 2, 0, 0, 0);

    @(negedge clk);
    check("model queue empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
